// File: rtl/pipeline_pkg.sv
// Shared pipeline bundle types, memory-stage FSM states and access-size codes.
// Imported by stage_mem and mem_lane.
package pipeline_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        BEAT1,
        BEAT2
    } mem_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        w_rd;
        logic        mem_r;
        logic        mem_w;
        logic [1:0]  mem_sz;
        logic        mem_sx;
        logic [31:0] wdata;
        logic        bubble;
    } ex_out_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        w_rd;
        logic        mem_r;
        logic [1:0]  mem_sz;
        logic        mem_sx;
        logic        bubble;
    } mem_out_t;

endpackage

// File: rtl/stage_mem_lane.sv
// mem_lane: per-beat store lane shift, byte enables and load extraction.
// beat2 selects the upper word of a two-beat access; hold carries the BEAT1 data.
module mem_lane
    import pipeline_pkg::*;
(
    input  logic [1:0]  sz,
    input  logic [1:0]  a,
    input  logic        beat2,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic [31:0] hold,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rlane
);

    logic [3:0]  mask;
    logic [31:0] keep;
    logic [7:0]  be_w;
    logic [63:0] wd_w;
    logic [31:0] lo;
    logic [23:0] hi;
    logic [31:0] sh;

    always_comb begin
        unique case (1'b1)
            sz == SZ_B: begin
                mask = 4'b0001;
                keep = 32'h0000_00ff;
            end
            sz == SZ_H: begin
                mask = 4'b0011;
                keep = 32'h0000_ffff;
            end
            default: begin
                mask = 4'b1111;
                keep = 32'hffff_ffff;
            end
        endcase
    end

    // Shift over a double word; the upper half feeds the second beat.
    assign be_w  = {4'b0000, mask} << a;
    assign wd_w  = {32'h0, wdata} << {a, 3'b000};
    assign be    = beat2 ? be_w[7:4] : be_w[3:0];
    assign wlane = beat2 ? wd_w[63:32] : wd_w[31:0];

    assign lo = beat2 ? hold : rdata;
    assign hi = beat2 ? rdata[23:0] : 24'h0;

    always_comb begin
        unique case (a)
            2'd0:    sh = lo;
            2'd1:    sh = {hi[7:0], lo[31:8]};
            2'd2:    sh = {hi[15:0], lo[31:16]};
            default: sh = {hi[23:0], lo[31:24]};
        endcase
    end

    assign rlane = sh & keep;

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: registers the execute bundle and runs loads/stores on dmem.
// Define STAGE_MEM_MISALIGN_EN to split misaligned half/word accesses into two beats.
module stage_mem
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  ex_out_t     EX,
    output mem_out_t    out,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam ex_out_t EX_RST = '{bubble: 1'b1, default: '0};

    ex_out_t     ex_q;
    mem_state_t  state_q, state_d;
    logic [31:0] hold_q;
    logic        mem_op, ex_mem_op, is_store;
    logic        split, beat2, final_beat, ack;
    logic [1:0]  a;
    logic [31:0] base, ld_data;

    assign mem_op    = (ex_q.mem_r | ex_q.mem_w) & ~ex_q.bubble;
    assign ex_mem_op = (EX.mem_r | EX.mem_w) & ~EX.bubble;
    assign is_store  = ex_q.mem_w & ~ex_q.mem_r;

`ifdef STAGE_MEM_MISALIGN_EN
    assign a     = ex_q.res[1:0];
    assign split = (ex_q.mem_sz == SZ_H) ? (a == 2'd3)
                 : (ex_q.mem_sz != SZ_B) && (a != 2'd0);
`else
    // Without split support the offset is forced to the access size.
    always_comb begin
        unique case (1'b1)
            ex_q.mem_sz == SZ_B: a = ex_q.res[1:0];
            ex_q.mem_sz == SZ_H: a = {ex_q.res[1], 1'b0};
            default:             a = 2'd0;
        endcase
    end
    assign split = 1'b0;
`endif

    assign beat2      = (state_q == BEAT2);
    assign dmem_req   = (state_q == BEAT1) | beat2;
    assign ack        = dmem_req & dmem_ack;
    assign final_beat = beat2 | ((state_q == BEAT1) & ~split);
    assign stall      = mem_op & ~(final_beat & ack);
    assign base       = {ex_q.res[31:2], 2'b00};
    assign dmem_addr  = beat2 ? base + 32'd4 : base;
    assign dmem_we    = dmem_req & is_store;

    mem_lane u_lane (
        .sz    (ex_q.mem_sz),
        .a     (a),
        .beat2 (beat2),
        .wdata (ex_q.wdata),
        .rdata (dmem_rdata),
        .hold  (hold_q),
        .be    (dmem_be),
        .wlane (dmem_wdata),
        .rlane (ld_data)
    );

    // A request starts on the same edge that captures the memory op.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            !stall:
                state_d = ex_mem_op ? BEAT1 : IDLE;
            state_q == BEAT1 && ack && split:
                state_d = BEAT2;
            state_q == IDLE && mem_op:
                state_d = BEAT1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= EX_RST;
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (!stall)
                ex_q <= EX;
            if (state_q == BEAT1 && ack && split)
                hold_q <= dmem_rdata;
        end
    end

    always_comb begin
        out        = '0;
        out.pc     = ex_q.pc;
        out.res    = (mem_op & ex_q.mem_r) ? ld_data : ex_q.res;
        out.rd     = ex_q.rd;
        out.w_rd   = ex_q.w_rd;
        out.mem_r  = ex_q.mem_r;
        out.mem_sz = ex_q.mem_sz;
        out.mem_sx = ex_q.mem_sx;
        out.bubble = ex_q.bubble | stall;
    end

endmodule
